dr: RTL and testbench
=====================

Name: dr

Overview:
- 8-bit data register (DR) in the CPU model datapath.
- Captures a byte from the internal data bus on a load enable.
- Drives the stored byte back onto the bus only while its output enable is asserted.
- A pure storage/bus-interface element with no arithmetic.

Parameters:
- WIDTH, 8, data width in bits of Din, Dout and the storage register.
- TRISTATE, 1, 1 = Dout goes high-impedance when output is disabled (shared-bus use); 0 = Dout driven to all-zeros when disabled (OR/mux bus use).
- RESET_VALUE, 0, value loaded into the register on reset.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- IDR  input  1  input (load) enable, active-high; when 1, Din is captured at the rising clk edge.
- EDR  input  1  output enable, active-high; when 1, the register contents drive Dout.
- Din  input  WIDTH  data from the bus.
- Dout  output  WIDTH  data to the bus; stored value when EDR=1, otherwise Z (TRISTATE=1) or 0 (TRISTATE=0).
- q  output  WIDTH  register contents, always driven, unaffected by EDR; used for debug and monitoring.

Behaviour:
- Storage register `r` of WIDTH bits.
- rst_n=0: `r` becomes RESET_VALUE immediately, independent of clk, and holds there while rst_n=0.
- Reset release is synchronous-safe: the first load can occur on the first rising edge with rst_n=1.
- Rising clk edge with rst_n=1 and IDR=1: `r` <= Din.
- Rising clk edge with IDR=0: `r` holds. No other path modifies `r`.
- Load latency: one edge. The value appears on q (and on Dout if EDR=1) right after the capturing edge.
- Dout is combinational from `r` and EDR:
  - EDR=1 -> Dout = r.
  - EDR=0 -> Dout = all-Z or all-0, per TRISTATE.
  - EDR changes reflect on Dout in the same cycle, with no clock involved.
- No Din->Dout bypass: with IDR=1 and EDR=1 together, Dout shows the old `r` until the edge, then the new value.
- Simultaneous IDR=1 and EDR=1 is legal. The register loads and outputs independently.
- Din changes between edges have no effect. Only the value present at the rising edge is captured.
- During reset, Dout follows EDR:
  - EDR=1 -> Dout shows RESET_VALUE.
  - EDR=0 -> Dout is Z or 0.
- Reset asserted mid-cycle while IDR=1: reset wins; no load occurs while rst_n=0.
- X on IDR at an edge is a verification error. The design need not define a result.

Decomposition:
- No package required. WIDTH and RESET_VALUE are module parameters.
- A shared CPU bus-width constant (8) may be placed in the common datapath package and passed in as WIDTH.
- No sub-modules. The tri-state/zero output gating stays inline as a single generate-selected assign.

Test Plan:
- Reset: rst_n=0 with EDR=1 -> Dout=8'h00 and q=8'h00 without any clk edge. With EDR=0 (TRISTATE=1) -> Dout=8'hzz.
- Load and drive: rst_n=1, IDR=1, EDR=1, Din=8'h13 -> after the next rising edge q=8'h13 and Dout=8'h13. Then EDR=0 -> Dout=8'hzz in the same cycle, q stays 8'h13.
- Hold: IDR=0, Din=8'h14, several edges -> q and Dout stay 8'h13.
- Reload while disabled: IDR=1, EDR=0, Din=8'h14, one edge -> q=8'h14, Dout=Z. Then EDR=1 -> Dout=8'h14 with no edge needed.
- Asynchronous reset mid-operation: q=8'h14, pulse rst_n=0 between edges -> q=8'h00 immediately. On release with IDR=1 and Din=8'hA5, the next edge gives q=8'hA5.
- TRISTATE=0 variant: EDR=0 -> Dout=8'h00. EDR=1 with q=8'h5A -> Dout=8'h5A. No-bypass check: IDR=1, EDR=1, Din changes from 8'h5A to 8'h3C before the edge -> Dout=8'h5A until the edge, 8'h3C after.

Source files
------------

// File: rtl/dr_pkg.sv
// Shared datapath constants for the CPU model.
package dr_pkg;
    localparam int unsigned CPU_BUS_W = 8;
endpackage

// File: rtl/dr.sv
// Data register on the CPU bus: loads Din on IDR, drives Dout from the stored byte on EDR.
// One-edge load latency; EDR gating is combinational; no backpressure, every enabled edge loads.
module dr
    import dr_pkg::*;
#(
    parameter int unsigned      WIDTH       = CPU_BUS_W,
    parameter bit               TRISTATE    = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IDR,
    input  logic             EDR,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Dout,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= RESET_VALUE;
        end else if (IDR) begin
            r <= Din;
        end
    end

    assign q = r;

    // Dout is taken from r only, never from Din, so a same-cycle load is not bypassed.
    generate
        if (TRISTATE) begin : g_tri
            assign Dout = EDR ? r : {WIDTH{1'bz}};
        end else begin : g_zero
            assign Dout = EDR ? r : '0;
        end
    endgenerate

endmodule

// File: tb/tb_dr.sv
module tb_dr;
    localparam int W = 8;
    localparam logic [W-1:0] RV = 8'h00;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         idr = 1'b0;
    logic         edr = 1'b0;
    logic [W-1:0] din = '0;
    wire  [W-1:0] bus;
    wire  [W-1:0] dout_z;
    logic [W-1:0] q_t;
    logic [W-1:0] q_z;

    logic         tb_en = 1'b0;
    logic [W-1:0] tb_val = '0;
    assign bus = tb_en ? tb_val : {W{1'bz}};

    int checks = 0;
    int errors = 0;
    logic [W-1:0] m;

    always #5 clk = ~clk;

    dr #(.WIDTH(W), .TRISTATE(1'b1), .RESET_VALUE(RV)) dut_t (
        .clk(clk), .rst_n(rst_n), .IDR(idr), .EDR(edr),
        .Din(din), .Dout(bus), .q(q_t)
    );

    dr #(.WIDTH(W), .TRISTATE(1'b0), .RESET_VALUE(RV)) dut_z (
        .clk(clk), .rst_n(rst_n), .IDR(idr), .EDR(edr),
        .Din(din), .Dout(dout_z), .q(q_z)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Shared-bus view: when disabled, the tristate DUT must release the bus so another driver wins.
    task automatic check_bus(input string name, input logic [W-1:0] exp_q);
        if (edr) begin
            tb_en = 1'b0;
            #1;
            check({name, " bus driven"}, bus, exp_q);
        end else begin
            tb_val = ~exp_q;
            tb_en  = 1'b1;
            #1;
            check({name, " bus released"}, bus, ~exp_q);
            tb_en = 1'b0;
        end
    endtask

    task automatic check_all(input string name, input logic [W-1:0] exp_q, input logic [W-1:0] exp_dz);
        check({name, " q tri"}, q_t, exp_q);
        check({name, " q zero"}, q_z, exp_q);
        check({name, " dout zero"}, dout_z, exp_dz);
        check_bus(name, exp_q);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string        name;
        logic         rst_n;
        logic         idr;
        logic         edr;
        logic [W-1:0] din;
        bit           edge_;
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_dz;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"reset_en",      1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{"reset_dis",     1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{"load13",        1'b1, 1'b1, 1'b1, 8'h13, 1'b1, 8'h13, 8'h13});
        vecs.push_back('{"disable",       1'b1, 1'b0, 1'b0, 8'h14, 1'b0, 8'h13, 8'h00});
        vecs.push_back('{"hold1",         1'b1, 1'b0, 1'b1, 8'h14, 1'b1, 8'h13, 8'h13});
        vecs.push_back('{"hold2",         1'b1, 1'b0, 1'b1, 8'h14, 1'b1, 8'h13, 8'h13});
        vecs.push_back('{"reload_dis",    1'b1, 1'b1, 1'b0, 8'h14, 1'b1, 8'h14, 8'h00});
        vecs.push_back('{"enable_noedge", 1'b1, 1'b0, 1'b1, 8'h14, 1'b0, 8'h14, 8'h14});
        vecs.push_back('{"load5a",        1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 8'h5A, 8'h5A});

        // Table phase; the reset rows are applied before any clock edge.
        #1;
        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n;
            idr   = vecs[i].idr;
            edr   = vecs[i].edr;
            din   = vecs[i].din;
            if (vecs[i].edge_) tick();
            else #1;
            check_all(vecs[i].name, vecs[i].exp_q, vecs[i].exp_dz);
        end

        // Asynchronous reset between edges while a load is requested.
        idr = 1'b1; din = 8'h77; edr = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", RV, RV);
        tick();
        check_all("rst_beats_load", RV, RV);
        din = 8'hA5; rst_n = 1'b1;
        tick();
        check_all("first_load_after_rst", 8'hA5, 8'hA5);

        // No bypass from Din, and only the value at the edge is captured.
        idr = 1'b1; din = 8'h5A;
        tick();
        din = 8'h3C;
        #1;
        check_all("no_bypass_before", 8'h5A, 8'h5A);
        din = 8'h99;
        #1;
        din = 8'h3C;
        tick();
        check_all("no_bypass_after", 8'h3C, 8'h3C);

        // Randomized phase against a cycle-level model of the register.
        m = 8'h3C;
        for (int c = 0; c < 300; c++) begin
            rst_n = ($urandom_range(0, 15) != 0);
            idr   = $urandom_range(0, 1) == 1;
            edr   = $urandom_range(0, 1) == 1;
            din   = W'($urandom);
            if (!rst_n) m = RV;
            #1;
            check_all("rand_mid", m, edr ? m : '0);
            @(posedge clk);
            if (rst_n && idr) m = din;
            #1;
            check_all("rand_post", m, edr ? m : '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
